btn_num_gen: RTL and testbench

//   Converts the four raw board push-buttons into a stable 16-bit value for the 7-segment display driver.

---
 rtl/lab_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/btn_num_gen.sv | 93 +++++++++
 tb/tb_btn_num_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared widths, direction encoding and digit-step helper for the button/number front end.
package lab_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int BTN_W      = 4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [DIGIT_W-1:0] DIGIT_ONE = 1;

    // Digits wrap inside 4 bits; no carry or borrow reaches the neighbour digit.
    function automatic logic [DIGIT_W-1:0] step_digit(input logic [DIGIT_W-1:0] d, input logic dir);
        case (dir)
            DIR_UP:   return d + DIGIT_ONE;
            DIR_DOWN: return d - DIGIT_ONE;
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, debounce counter, accepted level and
// a single-cycle step on the released->pressed transition of that level.
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic step
);

    logic        sync1_reg, sync2_reg;
    logic        stable_reg, stable_next;
    logic        stable_prev_reg;
    logic [19:0] cnt_reg, cnt_next;

    // A toggle happens on the edge where the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (sync2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg >= DEBOUNCE_CYCLES - 20'd1) begin
            stable_next = ~stable_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + 20'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            stable_reg      <= 1'b0;
            stable_prev_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            sync1_reg       <= btn;
            sync2_reg       <= sync1_reg;
            stable_reg      <= stable_next;
            stable_prev_reg <= stable_reg;
            cnt_reg         <= cnt_next;
        end
    end

    assign level = stable_reg;
    assign step  = stable_reg & ~stable_prev_reg;

endmodule

// File: rtl/btn_num_gen.sv
// Four debounced buttons step the four hex digits of num up or down (by dir).
// Optional hold-to-repeat stepping is built when AUTO_REPEAT_EN is defined.
module btn_num_gen
    import lab_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [15:0] INIT_VALUE      = 16'h0000,
    parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
    parameter logic [24:0] REPEAT_PERIOD   = 25'd5000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BTN_W-1:0]              btn,
    input  logic                          dir,
    output logic [NUM_DIGITS*DIGIT_W-1:0] num,
    output logic [BTN_W-1:0]              press
);

    logic [BTN_W-1:0]              level;
    logic [BTN_W-1:0]              step;
    logic [BTN_W-1:0]              step_all;
    logic [NUM_DIGITS*DIGIT_W-1:0] num_reg, num_next;
    logic [BTN_W-1:0]              press_reg;

    generate
        for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn[gi]),
                .level(level[gi]),
                .step (step[gi])
            );

`ifdef AUTO_REPEAT_EN
            // Counter is 1 on the cycle after any step, so a match at N fires N edges later.
            logic [24:0] rep_cnt_reg;
            logic        rep_first_reg;
            logic        rep_fire;

            assign rep_fire = level[gi] && (rep_cnt_reg != '0) &&
                              (rep_cnt_reg == (rep_first_reg ? REPEAT_DELAY : REPEAT_PERIOD));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rep_cnt_reg   <= '0;
                    rep_first_reg <= 1'b1;
                end else if (!level[gi]) begin
                    rep_cnt_reg   <= '0;
                    rep_first_reg <= 1'b1;
                end else if (step[gi]) begin
                    rep_cnt_reg   <= 25'd1;
                    rep_first_reg <= 1'b1;
                end else if (rep_fire) begin
                    rep_cnt_reg   <= 25'd1;
                    rep_first_reg <= 1'b0;
                end else if (rep_cnt_reg != '0) begin
                    rep_cnt_reg   <= rep_cnt_reg + 25'd1;
                end
            end

            assign step_all[gi] = step[gi] | rep_fire;
`else
            assign step_all[gi] = step[gi];
`endif

            assign num_next[gi*DIGIT_W +: DIGIT_W] = step_all[gi] ?
                step_digit(num_reg[gi*DIGIT_W +: DIGIT_W], dir) :
                num_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

`ifndef AUTO_REPEAT_EN
    logic [49:0] unused_repeat_cfg;
    assign unused_repeat_cfg = {REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_reg   <= INIT_VALUE;
            press_reg <= '0;
        end else begin
            num_reg   <= num_next;
            press_reg <= step_all;
        end
    end

    assign num   = num_reg;
    assign press = press_reg;

endmodule

// File: tb/tb_btn_num_gen.sv
// Self-checking bench for btn_num_gen: directed scenarios plus random bouncing
// buttons, compared against a sample-window behavioural model.
module tb_btn_num_gen;

    localparam int          D     = 4;
    localparam int          RD    = 20;
    localparam int          RP    = 8;
    localparam logic [15:0] INIT  = 16'h0000;
`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic        dir;
    logic [15:0] num;
    logic [3:0]  press;

    btn_num_gen #(
        .DEBOUNCE_CYCLES(20'd4),
        .INIT_VALUE     (INIT),
        .REPEAT_DELAY   (25'd20),
        .REPEAT_PERIOD  (25'd8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .dir  (dir),
        .num  (num),
        .press(press)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: last D+2 raw samples per button, accepted level, pending step, last step edge.
    bit          hist[4][D+2];
    bit          st_m[4];
    bit          pend[4];
    int          e_edge[4];
    logic [15:0] exp_num;
    logic [3:0]  exp_press;
    int          cyc = 0;
    int          exp_press_cnt = 0;
    int          seen_press_cnt = 0;
    int          mism = 0;

    always @(negedge clk) begin
        seen_press_cnt <= seen_press_cnt + $countones(press);
        if (num !== exp_num || press !== exp_press) mism <= mism + 1;
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < D + 2; j++) hist[i][j] = 1'b0;
            st_m[i]   = 1'b0;
            pend[i]   = 1'b0;
            e_edge[i] = -1;
        end
        exp_num   = INIT;
        exp_press = 4'h0;
    endtask

    task automatic tick();
        logic [3:0] ev;
        logic [3:0] d;
        int         n;
        bit         all_diff;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            ev = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) ev[i] = 1'b1;
                else if (REPEAT_ON && st_m[i] && e_edge[i] >= 0) begin
                    n = cyc - e_edge[i];
                    if (n == RD || (n > RD && (n - RD) % RP == 0)) ev[i] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (ev[i]) begin
                    d = exp_num[4*i +: 4];
                    exp_num[4*i +: 4] = dir ? d - 4'd1 : d + 4'd1;
                end
            end
            exp_press = ev;
            exp_press_cnt += $countones(ev);
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) e_edge[i] = cyc;
                pend[i] = 1'b0;
                for (int j = D + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = btn[i];
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++) if (hist[i][j] == st_m[i]) all_diff = 1'b0;
                if (all_diff) begin
                    st_m[i] = ~st_m[i];
                    if (st_m[i]) pend[i] = 1'b1;
                    else e_edge[i] = -1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [3:0] b, input int n);
        btn = b;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        btn = 4'h0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        btn = 4'hF;
        dir = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            @(negedge clk);
            total++;
            if (num !== INIT || press !== 4'h0) begin
                bad++;
                $display("FAIL reset_hold: num=%h press=%b expected num=%h press=0000", num, press, INIT);
            end
        end
        rst = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            @(negedge clk);
            total++;
            if (press !== ((j == 7) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL reset_release_press: edge %0d press=%b expected %b", j, press, (j == 7) ? 4'hF : 4'h0);
            end
        end
        total++;
        if (num !== 16'h1111) begin
            bad++;
            $display("FAIL reset_release_num: num=%h expected 1111", num);
        end
        drive(4'h0, 10);
        $display("test_reset: num=%h", num);
    endtask

    task automatic test_clean_press();
        int m0, p0;
        do_reset();
        dir = 1'b0;
        btn = 4'h1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            @(negedge clk);
            total++;
            if (press !== ((j == 7) ? 4'h1 : 4'h0)) begin
                bad++;
                $display("FAIL clean_press_timing: edge %0d press=%b expected %b", j, press, (j == 7) ? 4'h1 : 4'h0);
            end
        end
        @(negedge clk); #1;
        m0 = mism;
        p0 = seen_press_cnt;
        drive(4'h1, 100);
        @(negedge clk); #1;
        total++;
        if (num !== 16'h0001 || seen_press_cnt != p0 || mism != m0) begin
            bad++;
            $display("FAIL clean_press_hold: num=%h extra_press=%0d model_diffs=%0d expected num=0001 0 0",
                     num, seen_press_cnt - p0, mism - m0);
        end
        drive(4'h0, 10);
        $display("test_clean_press: num=%h", num);
    endtask

    task automatic test_bounce();
        int p0;
        logic [3:0] d0;
        @(negedge clk); #1;
        p0 = seen_press_cnt;
        d0 = num[11:8];
        drive(4'h4, 2); drive(4'h0, 2); drive(4'h4, 2); drive(4'h0, 2);
        @(negedge clk); #1;
        total++;
        if (seen_press_cnt != p0) begin
            bad++;
            $display("FAIL bounce_no_press: presses=%0d expected 0", seen_press_cnt - p0);
        end
        drive(4'h4, 12);
        drive(4'h0, 3);
        drive(4'h4, 8);
        drive(4'h0, 12);
        @(negedge clk); #1;
        total++;
        if (seen_press_cnt != p0 + 1 || num[11:8] !== d0 + 4'd1) begin
            bad++;
            $display("FAIL bounce_single_press: presses=%0d digit=%h expected 1 %h",
                     seen_press_cnt - p0, num[11:8], d0 + 4'd1);
        end
        $display("test_bounce: num=%h", num);
    endtask

    task automatic test_wrap_direction();
        do_reset();
        dir = 1'b1;
        drive(4'h8, 10); drive(4'h0, 10);
        total++;
        if (num !== 16'hF000) begin
            bad++;
            $display("FAIL wrap_down_setup: num=%h expected f000", num);
        end
        dir = 1'b0;
        drive(4'h8, 10); drive(4'h0, 10);
        total++;
        if (num !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_up_no_carry: num=%h expected 0000", num);
        end
        dir = 1'b1;
        drive(4'h2, 10); drive(4'h0, 10);
        total++;
        if (num !== 16'h00F0) begin
            bad++;
            $display("FAIL wrap_down_no_borrow: num=%h expected 00f0", num);
        end
        $display("test_wrap_direction: num=%h", num);
    endtask

    task automatic test_simultaneous_reset();
        int p0;
        do_reset();
        dir = 1'b0;
        btn = 4'b1001;
        for (int j = 1; j <= 9; j++) begin
            tick();
            @(negedge clk);
            total++;
            if (press !== ((j == 7) ? 4'b1001 : 4'b0000)) begin
                bad++;
                $display("FAIL simultaneous_press: edge %0d press=%b expected %b", j, press, (j == 7) ? 4'b1001 : 4'b0000);
            end
        end
        total++;
        if (num !== 16'h1001) begin
            bad++;
            $display("FAIL simultaneous_num: num=%h expected 1001", num);
        end
        drive(4'h0, 10);
        @(negedge clk); #1;
        p0 = seen_press_cnt;
        drive(4'h2, 4);
        rst = 1'b1;
        model_reset();
        btn = 4'h0;
        repeat (2) tick();
        rst = 1'b0;
        drive(4'h0, 15);
        @(negedge clk); #1;
        total++;
        if (num !== INIT || seen_press_cnt != p0) begin
            bad++;
            $display("FAIL reset_mid_debounce: num=%h presses=%0d expected %h 0", num, seen_press_cnt - p0, INIT);
        end
        $display("test_simultaneous_reset: num=%h", num);
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int p0;
        do_reset();
        dir = 1'b0;
        @(negedge clk); #1;
        p0 = seen_press_cnt;
        drive(4'h2, 60);
        drive(4'h0, 40);
        @(negedge clk); #1;
        total++;
        if (num[7:4] !== 4'd6 || seen_press_cnt != p0 + 6) begin
            bad++;
            $display("FAIL auto_repeat: digit=%h presses=%0d expected 6 6", num[7:4], seen_press_cnt - p0);
        end
        $display("test_auto_repeat: num=%h", num);
    endtask
`endif

    task automatic test_random();
        int m0, p0, e0;
        do_reset();
        @(negedge clk); #1;
        m0 = mism;
        p0 = seen_press_cnt;
        e0 = exp_press_cnt;
        for (int k = 0; k < 400; k++) begin
            dir = 1'($urandom_range(0, 1));
            drive(4'($urandom_range(0, 15)), $urandom_range(1, 9));
        end
        drive(4'h0, 15);
        @(negedge clk); #1;
        total++;
        if (mism != m0) begin
            bad++;
            $display("FAIL random_model: %0d cycles differ from model, final num=%h expected %h", mism - m0, num, exp_num);
        end
        total++;
        if (seen_press_cnt - p0 != exp_press_cnt - e0) begin
            bad++;
            $display("FAIL random_press_count: got %0d expected %0d", seen_press_cnt - p0, exp_press_cnt - e0);
        end
        $display("test_random: presses=%0d num=%h", seen_press_cnt - p0, num);
    endtask

    initial begin
        rst = 1'b1;
        btn = 4'h0;
        dir = 1'b0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap_direction();
        test_simultaneous_reset();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        test_random();
        @(negedge clk); #1;
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL whole_run_model: %0d cycles differ from model", mism);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
